furv_memwb: RTL

FURV_MEMWB -- requirements
Module: furv_memwb

---
 rtl/furv_pkg.sv | 11 +
 rtl/furv_memwb_if.sv | 13 +
 rtl/furv_load_align.sv | 20 ++
 rtl/furv_memwb.sv | 126 ++++++++++++
 4 files changed

// File: rtl/furv_pkg.sv
// furv_pkg: shared encodings for the FURV memory/writeback stage
package furv_pkg;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_SHIFT = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_U = 2'd3;
  localparam logic [1:0] MW_BYTE = 2'd0;
  localparam logic [1:0] MW_HALF = 2'd1;
  localparam logic [1:0] MW_WORD = 2'd2;
  typedef enum logic {IDLE, BUS} memwb_state_t;
endpackage

// File: rtl/furv_memwb_if.sv
// furv_memwb_if: classic pipelined-less data bus between MEMWB (master) and memory (slave)
interface furv_memwb_if;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [29:0] bus_adr;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack;
  modport master (output bus_cyc, bus_stb, bus_we, bus_sel, bus_adr, bus_dat_o, input bus_dat_i, bus_ack);
  modport slave (input bus_cyc, bus_stb, bus_we, bus_sel, bus_adr, bus_dat_o, output bus_dat_i, bus_ack);
endinterface

// File: rtl/furv_load_align.sv
// furv_load_align: extracts and sign/zero-extends a loaded byte, half or word
module furv_load_align
  import furv_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  byte_addr,
  input  logic [1:0]  width,
  input  logic        is_unsigned,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  // pick the addressed lane, then extend; width 3 falls through to the full word
  always_comb begin
    b = data[{byte_addr, 3'b000} +: 8];
    h = byte_addr[1] ? data[31:16] : data[15:0];
    result = width == MW_BYTE ? {{24{~is_unsigned & b[7]}}, b} :
             width == MW_HALF ? {{16{~is_unsigned & h[15]}}, h} : data;
  end
endmodule

// File: rtl/furv_memwb.sv
// furv_memwb: memory access + register writeback stage; FURV_MEMWB_FWD_EN adds fwd_* bypass ports
module furv_memwb
  import furv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        exm_mem,
  input  logic        exm_mem_write,
  input  logic [3:0]  exm_sel,
  input  logic [29:0] exm_addr,
  input  logic [31:0] exm_data_out,
  input  logic [1:0]  exm_mem_width,
  input  logic        exm_mem_unsigned,
  input  logic [1:0]  exm_byte_addr,
  input  logic [1:0]  exm_wb_sel,
  input  logic [31:0] exm_alu_results,
  input  logic [31:0] exm_shifter_results,
  input  logic [31:0] exm_adjacent_pc,
  input  logic [31:0] exm_u_results,
  input  logic [4:0]  exm_rd,
  input  logic        exm_reverse_wb,
  output logic        stall_o,
  furv_memwb_if.master bus,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
`ifdef FURV_MEMWB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);
  memwb_state_t state_q, state_d;
  logic        we_q, we_d, ld_uns_q, ld_uns_d;
  logic [3:0]  sel_q, sel_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [1:0]  ld_width_q, ld_width_d, ld_ba_q, ld_ba_d;
  logic        rf_we_q, rf_we_d, pend_v_q, pend_v_d;
  logic [4:0]  rf_rd_q, rf_rd_d, pend_rd_q, pend_rd_d;
  logic [31:0] rf_wdata_q, rf_wdata_d, pend_data_q, pend_data_d;
  logic        accept, ack, alu_we, ld_we;
  logic [31:0] wb_val, ld_val;
  furv_load_align u_align (
    .data(bus.bus_dat_i), .byte_addr(ld_ba_q), .width(ld_width_q),
    .is_unsigned(ld_uns_q), .result(ld_val)
  );
  assign bus.bus_cyc = state_q == BUS;
  assign bus.bus_stb = state_q == BUS;
  assign bus.bus_we = state_q == BUS && we_q;
  assign bus.bus_sel = sel_q;
  assign bus.bus_adr = adr_q;
  assign bus.bus_dat_o = dat_q;
  assign rf_we = rf_we_q;
  assign rf_rd = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
`ifdef FURV_MEMWB_FWD_EN
  assign fwd_valid = rf_we_q;
  assign fwd_rd = rf_rd_q;
  assign fwd_data = rf_wdata_q;
`endif
  // handshake qualifiers and the selected writeback value
  always_comb begin
    ack = state_q == BUS && bus.bus_ack;
    stall_o = state_q == BUS && !bus.bus_ack;
    accept = valid_i && !stall_o;
    wb_val = (exm_wb_sel == WB_ALU ? exm_alu_results : exm_wb_sel == WB_SHIFT ? exm_shifter_results :
              exm_wb_sel == WB_PC4 ? exm_adjacent_pc : exm_u_results) ^ {31'd0, exm_reverse_wb};
    alu_we = accept && !exm_mem && exm_rd != 5'd0;
    ld_we = ack && !we_q && ld_rd_q != 5'd0;
  end
  // bus FSM: launch on accepted memory op, hold request until ack
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    sel_d = sel_q;
    adr_d = adr_q;
    dat_d = dat_q;
    ld_rd_d = ld_rd_q;
    ld_width_d = ld_width_q;
    ld_uns_d = ld_uns_q;
    ld_ba_d = ld_ba_q;
    if (ack) state_d = IDLE;
    if (accept && exm_mem) begin
      state_d = BUS;
      we_d = exm_mem_write;
      sel_d = exm_sel;
      adr_d = exm_addr;
      dat_d = exm_data_out;
      ld_rd_d = exm_rd;
      ld_width_d = exm_mem_width;
      ld_uns_d = exm_mem_unsigned;
      ld_ba_d = exm_byte_addr;
    end
  end
  // writeback port; a one-entry slot absorbs an op accepted in the same cycle a load acks
  always_comb begin
    rf_we_d = pend_v_q | ld_we | alu_we;
    rf_rd_d = pend_v_q ? pend_rd_q : ld_we ? ld_rd_q : exm_rd;
    rf_wdata_d = pend_v_q ? pend_data_q : ld_we ? ld_val : wb_val;
    pend_v_d = pend_v_q ? (ld_we | alu_we) : (ld_we & alu_we);
    pend_rd_d = pend_v_q && ld_we ? ld_rd_q : exm_rd;
    pend_data_d = pend_v_q && ld_we ? ld_val : wb_val;
  end
  // state and pipeline registers; reset clears control only
  always_ff @(posedge clk) begin
    state_q <= rst_n ? state_d : IDLE;
    rf_we_q <= rst_n ? rf_we_d : 1'b0;
    pend_v_q <= rst_n ? pend_v_d : 1'b0;
    we_q <= rst_n ? we_d : 1'b0;
    sel_q <= sel_d;
    adr_q <= adr_d;
    dat_q <= dat_d;
    ld_rd_q <= ld_rd_d;
    ld_width_q <= ld_width_d;
    ld_uns_q <= ld_uns_d;
    ld_ba_q <= ld_ba_d;
    rf_rd_q <= rf_rd_d;
    rf_wdata_q <= rf_wdata_d;
    pend_rd_q <= pend_rd_d;
    pend_data_q <= pend_data_d;
  end
endmodule
